standoff_round_ctrl: RTL and testbench

//   Round sequencer directly upstream of the outcome calculator. On start it runs a

---
 rtl/standoff_round_ctrl.sv | 130 +++++++++++++
 tb/tb_standoff_round_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/standoff_round_ctrl.sv
// standoff_round_ctrl
//   Round sequencer feeding the outcome calculator. A start request runs a
//   NUM_BEATS-beat countdown of TICK_CYCLES clocks per beat. During the
//   countdown each player may lock one one-hot move. The two moves are then
//   revealed together with a one-cycle choice_valid pulse. Moves read as zero
//   until the reveal, so neither player can see the other's choice early.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   begin a round (level, honoured in IDLE and DONE only)
//   p1_btn[3:0]   in   player 1 move buttons, debounced, one-hot intent
//   p2_btn[3:0]   in   player 2 move buttons
//   p1_choice     out  revealed player 1 move, 0 while hidden
//   p2_choice     out  revealed player 2 move, 0 while hidden
//   choice_valid  out  one-cycle pulse on the first reveal cycle
//   p1_locked     out  player 1 has locked a move this round
//   p2_locked     out  player 2 has locked a move this round
//   beats_left    out  remaining countdown beats, for the display
//   busy          out  high while the round is in COUNT or REVEAL
module standoff_round_ctrl #(
    parameter int unsigned TICK_CYCLES    = 50_000_000,
    parameter int unsigned NUM_BEATS      = 3,
    parameter logic [3:0]  DEFAULT_CHOICE = 4'b0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] p1_btn,
    input  logic [3:0] p2_btn,
    output logic [3:0] p1_choice,
    output logic [3:0] p2_choice,
    output logic       choice_valid,
    output logic       p1_locked,
    output logic       p2_locked,
    output logic [3:0] beats_left,
    output logic       busy
);

    localparam int unsigned TW         = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [3:0]    BEATS_INIT = 4'(NUM_BEATS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REVEAL = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    p1_lock_reg;
    logic [3:0]    p2_lock_reg;
    logic          p1_onehot;
    logic          p2_onehot;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign p1_onehot = (p1_btn != 4'd0) && ((p1_btn & (p1_btn - 4'd1)) == 4'd0);
    assign p2_onehot = (p2_btn != 4'd0) && ((p2_btn & (p2_btn - 4'd1)) == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            p1_lock_reg  <= '0;
            p2_lock_reg  <= '0;
            p1_choice    <= '0;
            p2_choice    <= '0;
            choice_valid <= 1'b0;
            p1_locked    <= 1'b0;
            p2_locked    <= 1'b0;
            beats_left   <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    choice_valid <= 1'b0;
                    if (start) begin
                        state       <= COUNT;
                        beats_left  <= BEATS_INIT;
                        tick_cnt    <= '0;
                        p1_locked   <= 1'b0;
                        p2_locked   <= 1'b0;
                        p1_lock_reg <= '0;
                        p2_lock_reg <= '0;
                        p1_choice   <= '0;
                        p2_choice   <= '0;
                        busy        <= 1'b1;
                    end
                end

                COUNT: begin
                    // Locks are taken on every COUNT cycle, the final one included.
                    if (!p1_locked && p1_onehot) begin
                        p1_locked   <= 1'b1;
                        p1_lock_reg <= p1_btn;
                    end
                    if (!p2_locked && p2_onehot) begin
                        p2_locked   <= 1'b1;
                        p2_lock_reg <= p2_btn;
                    end

                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (beats_left == 4'd1) begin
                            state      <= REVEAL;
                            beats_left <= '0;
                        end else begin
                            beats_left <= beats_left - 4'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                REVEAL: begin
                    state        <= DONE;
                    choice_valid <= 1'b1;
                    busy         <= 1'b0;
                    p1_choice    <= p1_locked ? p1_lock_reg : DEFAULT_CHOICE;
                    p2_choice    <= p2_locked ? p2_lock_reg : DEFAULT_CHOICE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_standoff_round_ctrl.sv
module tb_standoff_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] p1_btn = '0;
    logic [3:0] p2_btn = '0;
    logic [3:0] p1_choice, p2_choice, beats_left;
    logic       choice_valid, p1_locked, p2_locked, busy;

    int total = 0;
    int bad   = 0;

    standoff_round_ctrl #(
        .TICK_CYCLES   (4),
        .NUM_BEATS     (3),
        .DEFAULT_CHOICE(4'b0001)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .p1_btn      (p1_btn),
        .p2_btn      (p2_btn),
        .p1_choice   (p1_choice),
        .p2_choice   (p2_choice),
        .choice_valid(choice_valid),
        .p1_locked   (p1_locked),
        .p2_locked   (p2_locked),
        .beats_left  (beats_left),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Button schedule indexed by COUNT cycle (1..12); index 13 is the REVEAL cycle.
    typedef struct {
        logic [13:1][3:0] p1_seq;
        logic [13:1][3:0] p2_seq;
        logic [3:0]       e_p1;
        logic [3:0]       e_p2;
        logic             e_l1;
        logic             e_l2;
    } vec_t;

    typedef struct {
        logic [3:0] e_p1;
        logic [3:0] e_p2;
        logic       e_l1;
        logic       e_l2;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".p1_choice"}, 32'(p1_choice), 0);
        chk({tag, ".p2_choice"}, 32'(p2_choice), 0);
        chk({tag, ".valid"}, 32'(choice_valid), 0);
        chk({tag, ".p1_locked"}, 32'(p1_locked), 0);
        chk({tag, ".p2_locked"}, 32'(p2_locked), 0);
        chk({tag, ".beats_left"}, 32'(beats_left), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    // Runs one round from IDLE/DONE. With hold=1, start stays high throughout and
    // the task returns on the reveal cycle so the caller can observe the restart.
    task automatic run_round(input vec_t v, input bit hold);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   seen;
        e.e_p1 = v.e_p1; e.e_p2 = v.e_p2; e.e_l1 = v.e_l1; e.e_l2 = v.e_l2;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            p1_btn = (cyc <= 13) ? v.p1_seq[cyc] : 4'd0;
            p2_btn = (cyc <= 13) ? v.p2_seq[cyc] : 4'd0;
            if (cyc <= 12) begin
                chk("count.beats_left", 32'(beats_left), 32'(3 - (cyc - 1) / 4));
                chk("count.hidden", 32'({p1_choice, p2_choice}), 0);
                chk("count.busy", 32'(busy), 1);
            end else if (cyc == 13) begin
                chk("reveal.beats_left", 32'(beats_left), 0);
                chk("reveal.pre_valid", 32'(choice_valid), 0);
            end
            if (choice_valid) begin
                seen = 1'b1;
                chk("latency", 32'(cyc - 1), 13);
                if (sb.size() == 0) begin
                    chk("sb.nonempty", 0, 1);
                end else begin
                    got = sb.pop_front();
                    chk("p1_choice", 32'(p1_choice), 32'(got.e_p1));
                    chk("p2_choice", 32'(p2_choice), 32'(got.e_p2));
                    chk("p1_locked", 32'(p1_locked), 32'(got.e_l1));
                    chk("p2_locked", 32'(p2_locked), 32'(got.e_l2));
                    chk("done.busy", 32'(busy), 0);
                end
            end
        end
        if (!seen) chk("choice_valid.timeout", 0, 1);
        p1_btn = '0;
        p2_btn = '0;
        if (!hold && seen) begin
            @(negedge clk);
            chk("pulse.one_cycle", 32'(choice_valid), 0);
            chk("done.p1_hold", 32'(p1_choice), 32'(v.e_p1));
            chk("done.p2_hold", 32'(p2_choice), 32'(v.e_p2));
        end
    endtask

    initial begin
        bit pulsed;

        for (int i = 0; i < 5; i++) begin
            tbl[i].p1_seq = '0;
            tbl[i].p2_seq = '0;
        end
        // 1: p1 at cycle 2, p2 at cycle 5
        tbl[0].p1_seq[2] = 4'b0010; tbl[0].p2_seq[5] = 4'b1000;
        tbl[0].e_p1 = 4'b0010; tbl[0].e_p2 = 4'b1000; tbl[0].e_l1 = 1; tbl[0].e_l2 = 1;
        // 2: no presses in COUNT; a press during REVEAL must be ignored
        tbl[1].p1_seq[13] = 4'b0100;
        tbl[1].e_p1 = 4'b0001; tbl[1].e_p2 = 4'b0001; tbl[1].e_l1 = 0; tbl[1].e_l2 = 0;
        // 3: invalid, then valid, then a later press that must be ignored
        tbl[2].p1_seq[2] = 4'b0110; tbl[2].p1_seq[4] = 4'b0100; tbl[2].p1_seq[6] = 4'b1000;
        tbl[2].e_p1 = 4'b0100; tbl[2].e_p2 = 4'b0001; tbl[2].e_l1 = 1; tbl[2].e_l2 = 0;
        // 4: p2 presses only on the final COUNT cycle
        tbl[3].p2_seq[12] = 4'b0010;
        tbl[3].e_p1 = 4'b0001; tbl[3].e_p2 = 4'b0010; tbl[3].e_l1 = 0; tbl[3].e_l2 = 1;
        // 5: all-ones ignored, simultaneous valid presses both taken
        tbl[4].p1_seq[1] = 4'b1111; tbl[4].p1_seq[3] = 4'b1000; tbl[4].p2_seq[3] = 4'b0100;
        tbl[4].e_p1 = 4'b1000; tbl[4].e_p2 = 4'b0100; tbl[4].e_l1 = 1; tbl[4].e_l2 = 1;

        #3 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Buttons in IDLE must not lock anything.
        p1_btn = 4'b0100;
        @(negedge clk);
        p1_btn = '0;
        chk_all_zero("idle");

        for (int i = 0; i < 5; i++) run_round(tbl[i], 1'b0);

        // start held through a whole round, then honoured in DONE
        run_round(tbl[0], 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("restart.p1_choice", 32'(p1_choice), 0);
        chk("restart.p2_choice", 32'(p2_choice), 0);
        chk("restart.beats_left", 32'(beats_left), 3);
        chk("restart.locks", 32'({p1_locked, p2_locked}), 0);
        chk("restart.valid", 32'(choice_valid), 0);
        chk("restart.busy", 32'(busy), 1);

        // Abort at COUNT cycle 6 with p1 locked
        for (int c = 2; c <= 6; c++) begin
            p1_btn = (c == 2) ? 4'b0010 : 4'b0000;
            if (c < 6) @(negedge clk);
        end
        chk("abort.pre_lock", 32'(p1_locked), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        pulsed = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (choice_valid) pulsed = 1'b1;
        end
        chk("abort.no_pulse", 32'(pulsed), 0);
        chk("abort.idle_busy", 32'(busy), 0);

        // Recovery after abort
        run_round(tbl[2], 1'b0);
        chk("sb.drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
